// File: rtl/sel_mux2_pkg.sv
// -----------------------------------------------------------------------------
// sel_mux2_pkg
//
// Shared definitions for the sel_mux2 operand selector.
//   - Width defaults and limits, plus a helper used for the elaboration check.
//   - Select encoding constants.
//   - Classification of what the output register does in a given cycle.
// -----------------------------------------------------------------------------
package sel_mux2_pkg;

    localparam int SEL_MUX2_DEFAULT_WIDTH = 1;
    localparam int SEL_MUX2_MAX_WIDTH     = 64;

    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;

    // Per-cycle action of the single-entry output register.
    typedef enum logic [1:0] {
        HS_IDLE   = 2'd0,  // empty, nothing offered
        HS_ACCEPT = 2'd1,  // load a new word (possibly replacing a consumed one)
        HS_DRAIN  = 2'd2,  // held word consumed, no refill
        HS_STALL  = 2'd3   // held word not consumed, hold everything
    } hs_action_e;

    function automatic bit sel_width_ok(input int width);
        return (width >= 1) && (width <= SEL_MUX2_MAX_WIDTH);
    endfunction

endpackage : sel_mux2_pkg

// File: rtl/sel_mux2_core.sv
// -----------------------------------------------------------------------------
// sel_mux2_core
//
// Pure combinational 2:1 word selection, bitwise over WIDTH. Shared by the
// registered path and the optional unregistered output of sel_mux2.
//
// Ports:
//   in0_i   [WIDTH-1:0]  word chosen when sel_i = SEL_IN0
//   in1_i   [WIDTH-1:0]  word chosen when sel_i = SEL_IN1
//   sel_i                select
//   out_o   [WIDTH-1:0]  selected word
// -----------------------------------------------------------------------------
module sel_mux2_core
    import sel_mux2_pkg::*;
#(
    parameter int WIDTH = SEL_MUX2_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] out_o
);

    always_comb begin
        out_o = (sel_i == SEL_IN1) ? in1_i : in0_i;
    end

endmodule : sel_mux2_core

// File: rtl/sel_mux2.sv
// -----------------------------------------------------------------------------
// sel_mux2
//
// Registered 2:1 word selector with valid/ready handshake. Chooses the true or
// inverted operand (or the carry-in constant) ahead of the adder, through one
// single-entry output register.
//
// Optional feature macro: SEL_MUX2_COMB_OUT_EN
//   defined   -> out_comb port present, equal to sel ? in1 : in0 at all times
//   undefined -> out_comb absent, block purely registered
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   upstream offers in0/in1/sel
//   in_ready   block accepts this cycle (!out_valid || out_ready)
//   in0, in1   candidate words [WIDTH-1:0]
//   sel        select, sampled with the data
//   out_valid  out holds an unconsumed result
//   out_ready  downstream consumes out this cycle
//   out        registered selected word [WIDTH-1:0]
//   out_comb   unregistered selection (SEL_MUX2_COMB_OUT_EN only)
// -----------------------------------------------------------------------------
module sel_mux2
    import sel_mux2_pkg::*;
#(
    parameter int WIDTH = SEL_MUX2_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SEL_MUX2_COMB_OUT_EN
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_comb
`else
    output logic [WIDTH-1:0] out
`endif
);

    generate
        if (!sel_width_ok(WIDTH)) begin : g_width_err
            $error("sel_mux2: WIDTH=%0d outside legal range 1..%0d",
                   WIDTH, SEL_MUX2_MAX_WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             valid_q;
    logic             valid_d;
    hs_action_e       action;

    sel_mux2_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .in0_i (in0),
        .in1_i (in1),
        .sel_i (sel),
        .out_o (out_next)
    );

    // Ready never looks at in_valid, so upstream may wait for ready safely.
    always_comb begin
        in_ready = !valid_q || out_ready;
    end

    // Accept takes priority: a consume and a refill in one cycle is an
    // accept that overwrites the consumed word with no bubble.
    always_comb begin
        action = HS_IDLE;
        if (in_valid && in_ready) begin
            action = HS_ACCEPT;
        end else if (valid_q && out_ready) begin
            action = HS_DRAIN;
        end else if (valid_q) begin
            action = HS_STALL;
        end
    end

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        case (action)
            HS_ACCEPT: begin
                out_d   = out_next;
                valid_d = 1'b1;
            end
            HS_DRAIN: begin
                valid_d = 1'b0;   // out keeps its last value
            end
            HS_STALL,
            HS_IDLE: begin
                out_d   = out_q;
                valid_d = valid_q;
            end
            default: begin
                out_d   = out_q;
                valid_d = valid_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        out       = out_q;
        out_valid = valid_q;
    end

`ifdef SEL_MUX2_COMB_OUT_EN
    // Zero-latency view of the same selection; ignores handshake and reset.
    always_comb begin
        out_comb = out_next;
    end
`endif

endmodule : sel_mux2

// File: tb/tb_sel_mux2.sv
// -----------------------------------------------------------------------------
// tb_sel_mux2
//
// Self-checking bench for sel_mux2 (WIDTH=4 main instance, WIDTH=1 instance for
// the carry-in use). A negedge monitor keeps a reference model of the output
// register and a scoreboard queue of expected words; scenario tasks add their
// own directed checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sel_mux2;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in0 = '0;
    logic [W-1:0] in1 = '0;
    logic         sel = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out;

    logic         c_in_valid = 1'b0;
    logic         c_in_ready;
    logic [0:0]   c_in0 = '0;
    logic [0:0]   c_in1 = '0;
    logic         c_sel = 1'b0;
    logic         c_out_valid;
    logic         c_out_ready = 1'b1;
    logic [0:0]   c_out;

`ifdef SEL_MUX2_COMB_OUT_EN
    logic [W-1:0] out_comb;
    logic [0:0]   c_out_comb;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sel_mux2 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SEL_MUX2_COMB_OUT_EN
        .out       (out),
        .out_comb  (out_comb)
`else
        .out       (out)
`endif
    );

    sel_mux2 #(.WIDTH(1)) dut_cin (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (c_in_valid),
        .in_ready  (c_in_ready),
        .in0       (c_in0),
        .in1       (c_in1),
        .sel       (c_sel),
        .out_valid (c_out_valid),
        .out_ready (c_out_ready),
`ifdef SEL_MUX2_COMB_OUT_EN
        .out       (c_out),
        .out_comb  (c_out_comb)
`else
        .out       (c_out)
`endif
    );

    // ---------------- reference model + scoreboard (main instance) ----------
    logic [W-1:0] exp_q[$];
    logic         m_valid = 1'b0;
    logic [W-1:0] m_last  = '0;

    always @(negedge clk) begin
        logic exp_rdy, consume, accept;
        if (rst) begin
            m_valid = 1'b0;
            m_last  = '0;
            exp_q.delete();
        end else begin
            exp_rdy = !m_valid || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL mon_in_ready t=%0t got %b exp %b", $time, in_ready, exp_rdy);
            end
            checks++;
            if (out_valid !== m_valid) begin
                errors++;
                $display("FAIL mon_out_valid t=%0t got %b exp %b", $time, out_valid, m_valid);
            end
            checks++;
            if (m_valid && exp_q.size() > 0) begin
                if (out !== exp_q[0]) begin
                    errors++;
                    $display("FAIL mon_out t=%0t got %h exp %h", $time, out, exp_q[0]);
                end
            end else if (out !== m_last) begin
                errors++;
                $display("FAIL mon_out_hold t=%0t got %h exp %h", $time, out, m_last);
            end
            consume = m_valid && out_ready;
            accept  = in_valid && exp_rdy;
            if (consume && exp_q.size() > 0) void'(exp_q.pop_front());
            if (accept) begin
                exp_q.push_back(sel ? in1 : in0);
                m_last = sel ? in1 : in0;
            end
            m_valid = (m_valid && !consume) || accept;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        #2;
        checks++;
        if (out !== 4'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got out=%h v=%b r=%b exp out=0 v=0 r=1", out, out_valid, in_ready);
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_basic_select();
        out_ready = 1'b1;
        in0 = 4'h5; in1 = 4'hA; sel = 1'b0; in_valid = 1'b1;
        next_cycle();
        checks++;
        if (out !== 4'h5 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_sel0 got out=%h v=%b exp out=5 v=1", out, out_valid);
        end
        sel = 1'b1;
        next_cycle();
        checks++;
        if (out !== 4'hA || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_sel1 got out=%h v=%b exp out=a v=1", out, out_valid);
        end
        in_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_invert();
        out_ready = 1'b1;
        in0 = 4'h3; in1 = 4'hC; sel = 1'b1; in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        checks++;
        if (out !== 4'hC) begin
            errors++;
            $display("FAIL invert got %h exp c", out);
        end
        next_cycle();
    endtask

    task automatic test_carry_in();
        c_in0 = 1'b0; c_in1 = 1'b1; c_sel = 1'b1; c_in_valid = 1'b1; c_out_ready = 1'b1;
        next_cycle();
        c_in_valid = 1'b0;
        checks++;
        if (c_out !== 1'b1 || c_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL carry_in got out=%b v=%b exp out=1 v=1", c_out, c_out_valid);
        end
        c_sel = 1'b0;
        c_in_valid = 1'b1;
        next_cycle();
        c_in_valid = 1'b0;
        checks++;
        if (c_out !== 1'b0) begin
            errors++;
            $display("FAIL carry_in_zero got %b exp 0", c_out);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in0 = 4'h5; in1 = 4'hA; sel = 1'b0; in_valid = 1'b1;
        next_cycle();
        sel = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready got %b exp 0", in_ready);
        end
        next_cycle();
        checks++;
        if (out !== 4'h5 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got out=%h v=%b exp out=5 v=1", out, out_valid);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready got %b exp 1", in_ready);
        end
        next_cycle();
        in_valid = 1'b0;
        checks++;
        if (out !== 4'hA || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_after got out=%h v=%b exp out=a v=1", out, out_valid);
        end
    endtask

    task automatic test_drain();
        out_ready = 1'b1; in_valid = 1'b0;
        next_cycle();
        checks++;
        if (out_valid !== 1'b0 || out !== 4'hA) begin
            errors++;
            $display("FAIL drain got out=%h v=%b exp out=a v=0", out, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3;
        out_ready = 1'b1; sel = 1'b0; in1 = 4'hF;
        for (int i = 0; i < 3; i++) begin
            in0 = words[i]; in_valid = 1'b1;
            next_cycle();
            checks++;
            if (out !== words[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d got out=%h v=%b exp out=%h v=1", i, out, out_valid, words[i]);
            end
        end
        in_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in0       = W'($urandom);
            in1       = W'($urandom);
            sel       = 1'($urandom_range(0, 1));
            next_cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in0 = 4'h9; sel = 1'b0; in_valid = 1'b1;
        next_cycle();
        checks++;
        if (out_valid !== 1'b1 || out !== 4'h9) begin
            errors++;
            $display("FAIL rst_mid_pre got out=%h v=%b exp out=9 v=1", out, out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 4'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async got out=%h v=%b r=%b exp out=0 v=0 r=1", out, out_valid, in_ready);
        end
        in0 = 4'h7;
        next_cycle();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 4'h0) begin
            errors++;
            $display("FAIL rst_mid_discard got out=%h v=%b exp out=0 v=0", out, out_valid);
        end
        next_cycle();
    endtask

`ifdef SEL_MUX2_COMB_OUT_EN
    task automatic test_comb_out();
        out_ready = 1'b1; in_valid = 1'b0;
        in0 = 4'h6; in1 = 4'h9; sel = 1'b0;
        #1;
        checks++;
        if (out_comb !== 4'h6) begin
            errors++;
            $display("FAIL comb_sel0 got %h exp 6", out_comb);
        end
        sel = 1'b1;
        #1;
        checks++;
        if (out_comb !== 4'h9 || out === 4'h9) begin
            errors++;
            $display("FAIL comb_sel1 got comb=%h out=%h exp comb=9 out!=9", out_comb, out);
        end
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        checks++;
        if (out !== 4'h9) begin
            errors++;
            $display("FAIL comb_reg got %h exp 9", out);
        end
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_select();
        test_invert();
        test_carry_in();
        test_backpressure();
        test_drain();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef SEL_MUX2_COMB_OUT_EN
        test_comb_out();
`endif
        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sel_mux2

// File: doc/sel_mux2.md
# sel_mux2

Registered 2:1 word selector with a valid/ready handshake. Sits at the operand-conditioning stage of the 4-bit arithmetic unit: it picks either a true or an inverted operand, and the carry-in constant, according to the add/subtract control. It drives the adder through one pipeline register.

## Interface
- WIDTH, default 1: data width of in0, in1 and out; legal range 1..64.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream offers in0/in1/sel this cycle.
- in_ready  output  1  block accepts the offer this cycle.
- in0  input  WIDTH  word selected when sel=0.
- in1  input  WIDTH  word selected when sel=1.
- sel  input  1  select; sampled together with the data.
- out_valid  output  1  out holds a result not yet consumed.
- out_ready  input  1  downstream consumes out this cycle.
- out  output  WIDTH  registered selected word.
- out_comb  output  WIDTH  unregistered selection. Present only with SEL_MUX2_COMB_OUT_EN.

## Operation
- The selection function is out_next = sel ? in1 : in0, applied bitwise over WIDTH.
- Single-entry output register holds {out, out_valid}.
- in_ready = !out_valid || out_ready. This is combinational and has no dependency on in_valid.
- Accept when in_valid && in_ready: out <= out_next and out_valid <= 1.
- Drain without refill when out_valid && out_ready && !in_valid: out_valid <= 0. out keeps its last value.
- Stall when out_valid && !out_ready: out and out_valid hold, and in_ready is 0.
- Simultaneous consume and accept in the same cycle: the new word replaces the old one and out_valid stays 1, with no bubble.
- in_valid with in_ready=0 has no effect. Upstream holds its data until it is accepted.
- No arithmetic and no width changes. Bit i of out depends only on bit i of in0, in1 and on sel.

## Timing
- Reset (asynchronous assert, synchronous release): out = 0 and out_valid = 0. in_ready therefore reads 1 during and right after reset.
- Latency: 1 clk from acceptance to out_valid=1 with the corresponding out.
- Throughput: 1 word per cycle while out_ready is held at 1.
- Reset asserted mid-operation discards any held word. Nothing accepted in the reset cycle is retained.
- out_comb follows in0/in1/sel combinationally with zero cycles of latency, and is independent of handshake and reset.

## Configuration
- SEL_MUX2_COMB_OUT_EN defined: the out_comb port exists and equals sel ? in1 : in0 at all times.
- SEL_MUX2_COMB_OUT_EN undefined: the out_comb port is absent, and the block is purely registered.
- Registered behaviour is identical in both builds.

## Structure
- Shared package sel_mux2_pkg:
  - SEL_MUX2_DEFAULT_WIDTH = 1.
  - SEL_MUX2_MAX_WIDTH = 64.
  - Select encoding constants SEL_IN0 = 1'b0 and SEL_IN1 = 1'b1.
- One combinational sub-module, sel_mux2_core. It has only the WIDTH parameter and is pure selection logic, shared between out_next and out_comb.
- The top level holds the register, the handshake and the width check. An elaboration-time error is raised when WIDTH is outside 1..64.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 -> out=0, out_valid=0 and in_ready=1 immediately, without waiting for a clk edge.
- Basic select, WIDTH=4: in0=4'h5, in1=4'hA.
  - sel=0, accepted -> next cycle out=4'h5, out_valid=1.
  - sel=1 -> out=4'hA.
- Operand-invert use, WIDTH=4: in0=A=4'h3, in1=~A=4'hC, sel=1 -> out=4'hC. Carry-in use with WIDTH=1, in0=0, in1=1, sel=1 -> out=1.
- Backpressure: out_valid=1 holding 4'h5, out_ready=0, in_valid=1 offering 4'hA -> in_ready=0, out stays 4'h5. Raise out_ready -> 4'hA appears the following cycle.
- Streaming: out_ready=1, present 4'h1, 4'h2, 4'h3 on three consecutive cycles -> out shows 4'h1, 4'h2, 4'h3 on the next three cycles, out_valid stays 1, no bubbles.
- SEL_MUX2_COMB_OUT_EN build: toggle sel between edges -> out_comb changes the same cycle, and out changes only after acceptance at the next edge.
